// File: rtl/matmul_host_pkg.sv
// matmul_host shared types.
// Host FSM states and data width.
package matmul_host_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        LOAD_VEC,
        LOAD_MAT,
        START,
        WAIT_ACK,
        WAIT_DONE,
        DRAIN
    } host_state_t;

endpackage

// File: rtl/matmul_host_if.sv
// matmul_host bundle: input stream, result stream, engine port.
// slave = host side, master = driver/engine side.
interface matmul_host_if #(
    parameter int LEN_BITS = 2,
    parameter int COL_BITS = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [15:0]         in_data;
    logic                out_valid;
    logic                out_ready;
    logic [15:0]         out_data;
    logic                out_last;
    logic                mm_start;
    logic                mm_ready;
    logic [LEN_BITS-1:0] mm_sel_vec;
    logic [LEN_BITS-1:0] mm_sel_row;
    logic [COL_BITS-1:0] mm_sel_col;
    logic [15:0]         mm_data1;
    logic [15:0]         mm_data2;
    logic [COL_BITS-1:0] mm_sel;
    logic [15:0]         mm_data_out;

    modport slave (
        input  in_valid, in_data, out_ready,
        input  mm_ready, mm_sel_vec, mm_sel_row,
        input  mm_sel_col, mm_data_out,
        output in_ready, out_valid, out_data,
        output out_last, mm_start, mm_data1,
        output mm_data2, mm_sel
    );

    modport master (
        output in_valid, in_data, out_ready,
        output mm_ready, mm_sel_vec, mm_sel_row,
        output mm_sel_col, mm_data_out,
        input  in_ready, out_valid, out_data,
        input  out_last, mm_start, mm_data1,
        input  mm_data2, mm_sel
    );
endinterface

// File: rtl/matmul_host_operand_store.sv
// Operand storage: vector + row-major matrix.
// One synchronous write port, two async read ports.
module operand_store #(
    parameter int LEN_BITS = 2,
    parameter int COL_BITS = 4
) (
    input  logic                         clk,
    input  logic                         we_i,
    input  logic                         sel_mat_i,
    input  logic [LEN_BITS+COL_BITS-1:0] waddr_i,
    input  logic [15:0]                  wdata_i,
    input  logic [LEN_BITS-1:0]          vaddr_i,
    input  logic [LEN_BITS+COL_BITS-1:0] maddr_i,
    output logic [15:0]                  vdata_o,
    output logic [15:0]                  mdata_o
);
    localparam int NV = 2 ** LEN_BITS;
    localparam int NM = 2 ** (LEN_BITS + COL_BITS);

    logic [15:0] vec_q [NV];
    logic [15:0] mat_q [NM];

    // Write the selected array; contents are never cleared.
    always_ff @(posedge clk) begin
        if (we_i) begin
            if (sel_mat_i) begin
                mat_q[waddr_i] <= wdata_i;
            end else begin
                vec_q[waddr_i[LEN_BITS-1:0]] <= wdata_i;
            end
        end
    end

    assign vdata_o = vec_q[vaddr_i];
    assign mdata_o = mat_q[maddr_i];
endmodule

// File: rtl/matmul_host.sv
// Host initiator for the matmul engine.
// Loads operands, starts the engine, serves reads, drains results.
module matmul_host
    import matmul_host_pkg::*;
#(
    parameter int LEN_BITS = 2,
    parameter int COL_BITS = 4
) (
    input logic          clk,
    input logic          rst,
    matmul_host_if.slave bus
);
    localparam int CNT_W = LEN_BITS + COL_BITS;
    localparam logic [CNT_W-1:0] VEC_LAST = CNT_W'(2 ** LEN_BITS - 1);
    localparam logic [CNT_W-1:0] MAT_LAST = CNT_W'(2 ** CNT_W - 1);
    localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(2 ** COL_BITS - 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    host_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready, out_valid, mm_start;
    logic             we, sel_mat;
    logic             col_last;

    assign col_last = (cnt_q[COL_BITS-1:0] == COL_LAST);

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD_VEC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mm_start  = 1'b0;
        we        = 1'b0;
        sel_mat   = 1'b0;
        unique case (state_q)
            LOAD_VEC: begin
                in_ready = 1'b1;
                we       = bus.in_valid;
                if (bus.in_valid) begin
                    if (cnt_q == VEC_LAST) begin
                        cnt_d   = '0;
                        state_d = LOAD_MAT;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            LOAD_MAT: begin
                in_ready = 1'b1;
                we       = bus.in_valid;
                sel_mat  = 1'b1;
                if (bus.in_valid) begin
                    if (cnt_q == MAT_LAST) begin
                        cnt_d   = '0;
                        state_d = START;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            START: begin
                if (bus.mm_ready) begin
                    mm_start = 1'b1;
                    state_d  = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!bus.mm_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.mm_ready) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    if (col_last) begin
                        cnt_d   = '0;
                        state_d = LOAD_VEC;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            default: begin
                state_d = LOAD_VEC;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.mm_start  = mm_start;
    assign bus.out_data  = bus.mm_data_out;
    assign bus.out_last  = (state_q == DRAIN) && col_last;
    assign bus.mm_sel    = (state_q == DRAIN) ? cnt_q[COL_BITS-1:0] : '0;

    operand_store #(
        .LEN_BITS (LEN_BITS),
        .COL_BITS (COL_BITS)
    ) u_store (
        .clk       (clk),
        .we_i      (we),
        .sel_mat_i (sel_mat),
        .waddr_i   (cnt_q),
        .wdata_i   (bus.in_data),
        .vaddr_i   (bus.mm_sel_vec),
        .maddr_i   ({bus.mm_sel_row, bus.mm_sel_col}),
        .vdata_o   (bus.mm_data1),
        .mdata_o   (bus.mm_data2)
    );
endmodule

// File: tb/tb_matmul_host.sv
// Testbench for matmul_host with a behavioural matmul engine.
// Directed jobs plus random operands against a reference model.
module tb_matmul_host;
    localparam int LB = 2;
    localparam int CB = 4;
    localparam int NV = 4;
    localparam int NC = 16;
    localparam int NM = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matmul_host_if #(.LEN_BITS(LB), .COL_BITS(CB)) bus ();

    matmul_host #(.LEN_BITS(LB), .COL_BITS(CB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- engine model ----------------
    int          eng_st;
    logic [5:0]  eng_k;
    logic [15:0] acc [NC];

    assign bus.mm_ready    = (eng_st == 0);
    assign bus.mm_sel_vec  = eng_k[5:4];
    assign bus.mm_sel_row  = eng_k[5:4];
    assign bus.mm_sel_col  = eng_k[3:0];
    assign bus.mm_data_out = acc[bus.mm_sel];

    always @(posedge clk) begin
        if (rst) begin
            eng_st <= 0;
            eng_k  <= '0;
        end else begin
            case (eng_st)
                0: if (bus.mm_start) eng_st <= 1;
                1: begin
                    for (int c = 0; c < NC; c++) acc[c] <= '0;
                    eng_k  <= '0;
                    eng_st <= 2;
                end
                default: begin
                    acc[eng_k[3:0]] <= acc[eng_k[3:0]] +
                        16'((32'(bus.mm_data1) * 32'(bus.mm_data2)) >> 8);
                    eng_k <= eng_k + 6'd1;
                    if (eng_k == 6'd63) eng_st <= 0;
                end
            endcase
        end
    end

    // ---------------- monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_start = 0;
    int   start_cyc = 0;
    int   first_ov_cyc = 0;
    logic prev_ov = 1'b0;

    always @(negedge clk) begin
        if (!rst && bus.mm_start === 1'b1) begin
            n_start++;
            start_cyc = cyc;
            tests++;
            assert (bus.mm_ready === 1'b1) else begin
                fails++;
                $error("FAIL start_while_busy got=%b exp=1", bus.mm_ready);
            end
        end
        if (bus.out_valid === 1'b1 && prev_ov !== 1'b1) first_ov_cyc = cyc;
        prev_ov = bus.out_valid;
    end

    // ---------------- reference model ----------------
    logic [15:0] vec_m [NV];
    logic [15:0] mat_m [NM];

    function automatic logic [15:0] ref_out(int c);
        logic [15:0] s = '0;
        for (int r = 0; r < NV; r++)
            s += 16'((32'(vec_m[r]) * 32'(mat_m[r*NC+c])) >> 8);
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_basic();
        vec_m[0] = 16'h0100; vec_m[1] = 16'h0200;
        vec_m[2] = 16'h0000; vec_m[3] = 16'h0000;
        for (int i = 0; i < NM; i++)
            mat_m[i] = (i < NC) ? 16'h0100 : (i < 2*NC) ? 16'h0080 : 16'h0000;
    endtask

    task automatic set_job2();
        vec_m[0] = 16'h0300;
        for (int r = 1; r < NV; r++) vec_m[r] = '0;
        for (int i = 0; i < NM; i++)
            mat_m[i] = (i < NC) ? 16'h0100 : 16'($urandom);
    endtask

    task automatic set_random();
        for (int r = 0; r < NV; r++) vec_m[r] = 16'($urandom);
        for (int i = 0; i < NM; i++) mat_m[i] = 16'($urandom);
    endtask

    task automatic load(input int first, input int nmat, input bit gaps);
        int guard = 0;
        for (int i = first; i < NV + nmat; i++) begin
            logic acc_ok = 1'b0;
            while (!acc_ok) begin
                @(negedge clk);
                guard++;
                if (guard > 1000) begin
                    fails++;
                    $display("FAIL load_timeout got=%0d exp=%0d", i, NV + nmat);
                    bus.in_valid = 1'b0;
                    return;
                end
                if (gaps && $urandom_range(1) == 0) begin
                    bus.in_valid = 1'b0;
                end else begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = (i < NV) ? vec_m[i] : mat_m[i-NV];
                    #1;
                    acc_ok = bus.in_ready;
                end
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int stall_at, input int stall_len,
                         input bit hold_in, input logic [15:0] hold_word,
                         input int cexp);
        logic [15:0] exp [NC];
        int idx = 0;
        int st = 0;
        int guard = 0;
        bit stall;
        for (int c = 0; c < NC; c++)
            exp[c] = (cexp >= 0) ? 16'(cexp) : ref_out(c);
        while (idx < NC && guard < 400) begin
            @(negedge clk);
            guard++;
            if (hold_in) begin
                bus.in_valid = 1'b1;
                bus.in_data  = hold_word;
            end
            stall = (idx == stall_at) && (st < stall_len);
            bus.out_ready = !stall;
            #1;
            if (hold_in) chk("in_ready_drain", 32'(bus.in_ready), 0);
            if (bus.out_valid === 1'b1) begin
                chk("out_data", 32'(bus.out_data), 32'(exp[idx]));
                chk("out_last", 32'(bus.out_last), 32'(idx == NC - 1));
                chk("mm_sel", 32'(bus.mm_sel), 32'(idx));
                if (stall) st++;
                else idx++;
            end
        end
        if (idx < NC) begin
            fails++;
            $display("FAIL drain_timeout got=%0d exp=%0d", idx, NC);
        end
        if (stall_at >= 0) chk("stall_cycles", 32'(st), 32'(stall_len));
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        chk("ov_after", 32'(bus.out_valid), 0);
        if (hold_in) chk("in_ready_after", 32'(bus.in_ready), 1);
    endtask

    int s0;

    initial begin
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_last", 32'(bus.out_last), 0);
        chk("rst_mm_start", 32'(bus.mm_start), 0);
        chk("rst_mm_sel", 32'(bus.mm_sel), 0);
        chk("rst_out_data", 32'(bus.out_data), 32'(bus.mm_data_out));
        rst = 1'b0;

        // basic job, stall at word 3, in_valid held for next job
        set_basic();
        s0 = n_start;
        load(0, NM, 1'b0);
        drain(3, 5, 1'b1, 16'h0300, 16'h0200);
        chk("basic_starts", 32'(n_start - s0), 1);
        chk("latency", 32'(first_ov_cyc - start_cyc), 67);

        // back-to-back second job; word 0 already accepted
        set_job2();
        s0 = n_start;
        load(1, NM, 1'b0);
        drain(-1, 0, 1'b0, 16'h0, 16'h0300);
        chk("job2_starts", 32'(n_start - s0), 1);
        chk("job2_latency", 32'(first_ov_cyc - start_cyc), 67);

        // basic job with random in_valid gaps
        set_basic();
        load(0, NM, 1'b1);
        drain(-1, 0, 1'b0, 16'h0, 16'h0200);

        // random operands against the reference model
        for (int j = 0; j < 3; j++) begin
            set_random();
            load(0, NM, 1'b1);
            drain((j == 1) ? 7 : -1, 3, 1'b0, 16'h0, -1);
        end

        // reset mid-load after 10 matrix words
        set_random();
        load(0, 10, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_basic();
        s0 = n_start;
        load(0, NM, 1'b0);
        drain(-1, 0, 1'b0, 16'h0, 16'h0200);
        chk("rstload_starts", 32'(n_start - s0), 1);

        // reset mid-compute in WAIT_DONE
        set_basic();
        load(0, NM, 1'b0);
        begin
            int g = 0;
            while (bus.mm_ready !== 1'b0 && g < 20) begin
                @(negedge clk);
                g++;
            end
            chk("engine_busy", 32'(bus.mm_ready), 0);
        end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstc_out_valid", 32'(bus.out_valid), 0);
        chk("rstc_in_ready", 32'(bus.in_ready), 1);
        chk("rstc_mm_ready", 32'(bus.mm_ready), 1);

        // recovery job after reset
        set_basic();
        load(0, NM, 1'b0);
        drain(-1, 0, 1'b0, 16'h0, 16'h0200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
